// File: rtl/srff_upcount.sv
// srff_upcount: synchronous modulo-MODULUS up counter built from one SR flip-flop per bit.
// Define SRFF_UPCOUNT_SAT_EN for saturating mode (holds at MODULUS-1, wrap tied low).
module srff_upcount #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] ld_val;
  logic             at_last;
  logic             over;
  logic             carry;

  // Range guards only exist when the code space is not fully used.
  if (MODULUS < (2 ** WIDTH)) begin : g_partial
    assign over   = (q > LAST);
    assign ld_val = (din > LAST) ? '0 : din;
  end else begin : g_full
    assign over   = 1'b0;
    assign ld_val = din;
  end

  assign at_last = (q == LAST);

  // Ripple-carry toggle chain: bit i toggles when en and all lower bits are set.
  always_comb begin
    t     = '0;
    carry = en;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & q[i];
    end
  end

  // S/R excitation with priority reset > load > en > hold; S and R are exclusive per bit.
  always_comb begin
    s = '0;
    r = '0;
    if (!rst) begin
      r = q;
    end else if (load) begin
      s = ld_val & ~q;
      r = ~ld_val & q;
    end else if (en) begin
      if (over) begin
        r = q;
      end else if (at_last) begin
`ifdef SRFF_UPCOUNT_SAT_EN
        s = '0;
        r = '0;
`else
        r = q;
`endif
      end else begin
        s = t & ~q;
        r = t & q;
      end
    end
  end

  // One SR flip-flop cell per count bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_srff
    always_ff @(posedge clk) begin
      case ({s[i], r[i]})
        2'b10:   q[i] <= 1'b1;
        2'b01:   q[i] <= 1'b0;
        default: q[i] <= q[i];
      endcase
    end

    a_sr_excl: assert property (@(posedge clk) !(s[i] && r[i]));
  end

  assign count = q;
  assign tc    = en & at_last;

`ifdef SRFF_UPCOUNT_SAT_EN
  assign wrap = 1'b0;
`else
  // Pulse for the cycle after an increment rolls MODULUS-1 over to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= !load && en && at_last;
    end
  end
`endif

endmodule
